// File: rtl/cond_cc_unit.sv
// Condition-code register with exception freeze and branch/cmov condition decode.
// cnd is evaluated from the registered flags, so a flag load is first visible one cycle later.
module cond_cc_unit #(
  parameter logic [2:0] RESET_CC = 3'b001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_cc,
  input  logic [2:0] cf_in,
  input  logic       exc_in,
  input  logic       resume,
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  output logic [2:0] cc,
  output logic       cnd,
  output logic       frozen,
  output logic       cc_written
);

  localparam logic [0:0] StRun    = 1'b0;
  localparam logic [0:0] StFrozen = 1'b1;

  logic [0:0] state_d, state_q;
  logic [2:0] cc_d, cc_q;
  logic       cc_written_d, cc_written_q;

  always_comb begin
    state_d      = state_q;
    cc_d         = cc_q;
    cc_written_d = 1'b0;
    case (state_q)
      StRun: begin
        // An exception in flight suppresses the load on the same edge it freezes.
        if (exc_in) begin
          state_d = StFrozen;
        end else if (set_cc) begin
          cc_d         = cf_in;
          cc_written_d = 1'b1;
        end
      end
      default: begin
        if (resume && !exc_in) begin
          state_d = StRun;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      cc_q         <= RESET_CC;
      cc_written_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cc_q         <= cc_d;
      cc_written_q <= cc_written_d;
    end
  end

  logic zf, sf, of, lt;
  assign zf = cc_q[0];
  assign sf = cc_q[1];
  assign of = cc_q[2];
  assign lt = sf ^ of;

  always_comb begin
    cnd = 1'b0;
    if (icode == 4'h2 || icode == 4'h7) begin
      case (ifun)
        4'd0:    cnd = 1'b1;
        4'd1:    cnd = lt | zf;
        4'd2:    cnd = lt;
        4'd3:    cnd = zf;
        4'd4:    cnd = ~zf;
        4'd5:    cnd = ~lt;
        4'd6:    cnd = ~lt & ~zf;
        default: cnd = 1'b0;
      endcase
    end
  end

  assign cc         = cc_q;
  assign frozen     = (state_q == StFrozen);
  assign cc_written = cc_written_q;

endmodule

// File: tb/tb_cond_cc_unit.sv
// Directed and random checks of cond_cc_unit against a behavioural flag/condition model.
module tb_cond_cc_unit;

  logic       clk = 1'b0;
  logic       reset, set_cc, exc_in, resume;
  logic [2:0] cf_in;
  logic [3:0] icode, ifun;
  logic [2:0] cc;
  logic       cnd, frozen, cc_written;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [2:0] m_cc;
  logic       m_frozen, m_written;

  cond_cc_unit #(.RESET_CC(3'b001)) dut (
    .clk       (clk),
    .reset     (reset),
    .set_cc    (set_cc),
    .cf_in     (cf_in),
    .exc_in    (exc_in),
    .resume    (resume),
    .icode     (icode),
    .ifun      (ifun),
    .cc        (cc),
    .cnd       (cnd),
    .frozen    (frozen),
    .cc_written(cc_written)
  );

  always #5 clk = ~clk;

  function automatic logic ref_cnd(input logic [2:0] c, input logic [3:0] ic,
                                   input logic [3:0] fn);
    bit zf, sf, of, less;
    zf   = c[0];
    sf   = c[1];
    of   = c[2];
    less = (sf != of);
    if (ic != 4'h2 && ic != 4'h7) return 1'b0;
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return less || zf;
      4'd2:    return less;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return !less;
      4'd6:    return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".cc"},      {5'b0, cc},         {5'b0, m_cc});
    check({tag, ".cnd"},     {7'b0, cnd},        {7'b0, ref_cnd(m_cc, icode, ifun)});
    check({tag, ".frozen"},  {7'b0, frozen},     {7'b0, m_frozen});
    check({tag, ".written"}, {7'b0, cc_written}, {7'b0, m_written});
  endtask

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      m_cc = 3'b001; m_frozen = 1'b0; m_written = 1'b0;
    end else if (!m_frozen) begin
      m_written = 1'b0;
      if (exc_in) m_frozen = 1'b1;
      else if (set_cc) begin
        m_cc = cf_in; m_written = 1'b1;
      end
    end else begin
      m_written = 1'b0;
      if (resume && !exc_in) m_frozen = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; set_cc = 1'b0; exc_in = 1'b0; resume = 1'b0; cf_in = 3'b000;
  endtask

  initial begin
    m_cc = 3'b000; m_frozen = 1'b0; m_written = 1'b0;
    idle_inputs();
    icode = 4'h0; ifun = 4'h0;

    // Reset state
    reset = 1'b1; cycle(); cycle();
    reset = 1'b0; icode = 4'h7; ifun = 4'h3; #1;
    check("rst.cc", {5'b0, cc}, 8'h01);
    check("rst.cnd", {7'b0, cnd}, 8'h01);
    check("rst.frozen", {7'b0, frozen}, 8'h00);
    check("rst.written", {7'b0, cc_written}, 8'h00);

    // Load SF, then jl / jg
    set_cc = 1'b1; cf_in = 3'b010; cycle();
    set_cc = 1'b0; ifun = 4'h2; #1;
    check("ld.cc", {5'b0, cc}, 8'h02);
    check("ld.cnd_l", {7'b0, cnd}, 8'h01);
    check("ld.written", {7'b0, cc_written}, 8'h01);
    cycle();
    check("ld.written_pulse", {7'b0, cc_written}, 8'h00);
    ifun = 4'h6; #1;
    check("ld.cnd_g", {7'b0, cnd}, 8'h00);

    // cnd uses the registered flags, not cf_in
    ifun = 4'h2; set_cc = 1'b1; cf_in = 3'b110; #1;
    check("lat.old_cnd", {7'b0, cnd}, 8'h01);
    cycle();
    set_cc = 1'b0; ifun = 4'h5; #1;
    check("lat.cc", {5'b0, cc}, 8'h06);
    check("lat.cnd_ge", {7'b0, cnd}, 8'h01);

    // Exception blocks the concurrent load and freezes
    exc_in = 1'b1; set_cc = 1'b1; cf_in = 3'b100; cycle();
    check("exc.cc", {5'b0, cc}, 8'h06);
    check("exc.frozen", {7'b0, frozen}, 8'h01);
    check("exc.written", {7'b0, cc_written}, 8'h00);
    exc_in = 1'b0; cf_in = 3'b011; cycle(); cycle();
    check("frz.cc", {5'b0, cc}, 8'h06);
    check("frz.written", {7'b0, cc_written}, 8'h00);
    check("frz.cnd", {7'b0, cnd}, 8'h01);

    // Resume blocked by exception, then released
    set_cc = 1'b0; resume = 1'b1; exc_in = 1'b1; cycle();
    check("res.blocked", {7'b0, frozen}, 8'h01);
    exc_in = 1'b0; cycle();
    check("res.released", {7'b0, frozen}, 8'h00);
    resume = 1'b0; set_cc = 1'b1; cf_in = 3'b001; cycle();
    set_cc = 1'b0; #1;
    check("res.cc", {5'b0, cc}, 8'h01);

    // Decode corners
    icode = 4'h2; ifun = 4'h0; #1;
    check("dec.cmov_always", {7'b0, cnd}, 8'h01);
    for (int f = 0; f < 16; f++) begin
      icode = 4'h6; ifun = f[3:0]; #1;
      check("dec.other_icode", {7'b0, cnd}, 8'h00);
    end
    icode = 4'h7; ifun = 4'h9; #1;
    check("dec.bad_ifun", {7'b0, cnd}, 8'h00);

    // Reset wins while frozen
    set_cc = 1'b1; cf_in = 3'b110; cycle();
    exc_in = 1'b1; cycle();
    check("rf.pre_frozen", {7'b0, frozen}, 8'h01);
    reset = 1'b1; resume = 1'b1; cycle();
    check("rf.cc", {5'b0, cc}, 8'h01);
    check("rf.frozen", {7'b0, frozen}, 8'h00);
    check("rf.written", {7'b0, cc_written}, 8'h00);
    idle_inputs();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 31) == 0);
      set_cc = $urandom_range(0, 1);
      exc_in = ($urandom_range(0, 7) == 0);
      resume = ($urandom_range(0, 3) == 0);
      cf_in  = 3'($urandom_range(0, 7));
      icode  = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, 1) == 1) ? 4'h2 : 4'h7)
                                           : 4'($urandom_range(0, 15));
      ifun   = 4'($urandom_range(0, 8));
      #1;
      check_model("rnd.pre");
      cycle();
      check_model("rnd.post");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
